// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the SRAM port controller and its arbiter.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 8;
    localparam int SRAM_DATA_W = 160;
    localparam int SRAM_MASK_W = 8;
    localparam int LANE_W      = SRAM_DATA_W / SRAM_MASK_W;

    typedef enum logic {INIT, READY} state_t;

    typedef struct packed {
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
        logic [SRAM_MASK_W-1:0] mask;
    } wcmd_t;

endpackage

// File: rtl/sram_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both requesters contend.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr <= 1'b0;
        else if (en && req == 2'b11)
            rr <= ~rr;
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Front-end for a 1R/1W masked SRAM: zero-fill sweep, 2-way write arbitration, 1-cycle reads.
// Optional read-during-write bypass is built when SRAM_PORT_CTRL_BYPASS_EN is defined.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W,
    parameter int MASK_W = SRAM_MASK_W
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic [MASK_W-1:0] w0_mask,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic [MASK_W-1:0] w1_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic [ADDR_W-1:0] sram_r_addr,
    input  logic [DATA_W-1:0] sram_r_data,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_w_addr,
    output logic [DATA_W-1:0] sram_w_data,
    output logic [MASK_W-1:0] sram_w_mask
);

    localparam int LW     = DATA_W / MASK_W;
    localparam int STAGES = 1;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [1:0]        wgnt;
    wcmd_t             wcmd, wsel;
    logic              rd_acc;
    logic [ADDR_W-1:0] r_addr_q;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;
    logic [DATA_W-1:0] merged;

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .en    (init_done),
        .req   ({w1_valid, w0_valid}),
        .gnt   (wgnt)
    );

    assign w0_ready = wgnt[0];
    assign w1_ready = wgnt[1];

    always_comb begin
        wsel = '{addr: w0_addr, data: w0_data, mask: w0_mask};
        if (wgnt[1])
            wsel = '{addr: w1_addr, data: w1_data, mask: w1_mask};
    end

    // Sweep writes go out through the same write register as granted writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            sram_w_en <= 1'b0;
            wcmd      <= '0;
        end else if (state == INIT) begin
            sram_w_en <= 1'b1;
            wcmd      <= '{addr: init_cnt, data: '0, mask: '1};
            init_cnt  <= init_cnt + 1'b1;
            if (init_cnt == '1)
                state <= READY;
        end else begin
            init_done <= 1'b1;
            sram_w_en <= |wgnt;
            if (|wgnt)
                wcmd <= wsel;
        end
    end

    assign sram_w_addr = wcmd.addr;
    assign sram_w_data = wcmd.data;
    assign sram_w_mask = wcmd.mask;

    assign rd_ready    = init_done;
    assign rd_acc      = rd_valid & rd_ready;
    assign sram_r_addr = rd_acc ? rd_addr : r_addr_q;
    assign vld_pipe    = {vld_q, rd_acc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            r_addr_q <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (rd_acc)
                r_addr_q <= rd_addr;
        end
    end

`ifdef SRAM_PORT_CTRL_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [MASK_W-1:0] byp_mask;

    // The SRAM returns pre-write contents on a same-cycle collision; patch written lanes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
            byp_mask <= '0;
        end else if (rd_acc) begin
            byp_hit  <= sram_w_en && (sram_w_addr == rd_addr);
            byp_data <= sram_w_data;
            byp_mask <= sram_w_mask;
        end
    end

    for (genvar l = 0; l < MASK_W; l++) begin : g_lane
        assign merged[l*LW +: LW] = (byp_hit && byp_mask[l]) ? byp_data[l*LW +: LW]
                                                             : sram_r_data[l*LW +: LW];
    end
`else
    assign merged = sram_r_data;
`endif

    assign rd_resp_valid = vld_pipe[STAGES];
    assign rd_resp_data  = rd_resp_valid ? merged : '0;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural read-before-write SRAM model.
module tb_sram_port_ctrl;

    localparam int AW = 8;
    localparam int DW = 160;
    localparam int MW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          init_done;
    logic          w0_valid = 1'b0, w1_valid = 1'b0, rd_valid = 1'b0;
    logic          w0_ready, w1_ready, rd_ready;
    logic [AW-1:0] w0_addr = '0, w1_addr = '0, rd_addr = '0;
    logic [DW-1:0] w0_data = '0, w1_data = '0;
    logic [MW-1:0] w0_mask = '0, w1_mask = '0;
    logic          rd_resp_valid;
    logic [DW-1:0] rd_resp_data;
    logic [AW-1:0] sram_r_addr;
    logic [DW-1:0] sram_r_data = '0;
    logic          sram_w_en;
    logic [AW-1:0] sram_w_addr;
    logic [DW-1:0] sram_w_data;
    logic [MW-1:0] sram_w_mask;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] exp_mem [256];

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [1:0] ARB_V [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    localparam logic [1:0] ARB_G [9] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    sram_port_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .init_done     (init_done),
        .w0_valid      (w0_valid),
        .w0_ready      (w0_ready),
        .w0_addr       (w0_addr),
        .w0_data       (w0_data),
        .w0_mask       (w0_mask),
        .w1_valid      (w1_valid),
        .w1_ready      (w1_ready),
        .w1_addr       (w1_addr),
        .w1_data       (w1_data),
        .w1_mask       (w1_mask),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .sram_r_addr   (sram_r_addr),
        .sram_r_data   (sram_r_data),
        .sram_w_en     (sram_w_en),
        .sram_w_addr   (sram_w_addr),
        .sram_w_data   (sram_w_data),
        .sram_w_mask   (sram_w_mask)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin : sram_model
        logic [DW-1:0] wtmp;
        sram_r_data <= mem[sram_r_addr];
        if (sram_w_en) begin
            wtmp = mem[sram_w_addr];
            for (int l = 0; l < MW; l++)
                if (sram_w_mask[l]) wtmp[l*20 +: 20] = sram_w_data[l*20 +: 20];
            mem[sram_w_addr] <= wtmp;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic init_sweep(input string tag);
        int en_cnt, first_en, last_en, bad, done_cyc, early;
        en_cnt = 0; first_en = -1; last_en = -1; bad = 0; done_cyc = -1; early = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            @(posedge clock); #1;
            w0_valid = (k <= 250);
            w1_valid = (k <= 250);
            rd_valid = (k <= 250);
            @(negedge clock);
            if (sram_w_en) begin
                en_cnt++;
                if (first_en < 0) first_en = k;
                last_en = k;
                if (sram_w_addr != AW'(k - 1) || sram_w_data != '0 || sram_w_mask != 8'hFF) bad++;
            end
            if (init_done && done_cyc < 0) done_cyc = k;
            if (!init_done && (w0_ready || w1_ready || rd_ready)) early++;
        end
        chk({tag, "_en_cnt"},   DW'(en_cnt),   DW'(256));
        chk({tag, "_first"},    DW'(first_en), DW'(1));
        chk({tag, "_last"},     DW'(last_en),  DW'(256));
        chk({tag, "_bad_wr"},   DW'(bad),      DW'(0));
        chk({tag, "_done_cyc"}, DW'(done_cyc), DW'(257));
        chk({tag, "_early"},    DW'(early),    DW'(0));
    endtask

    initial begin
        logic [DW-1:0] d0, lo_ones;
        logic [AW-1:0] a0, a1;
        d0      = 160'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C;
        lo_ones = {{80{1'b0}}, {80{1'b1}}};
        for (int i = 0; i < 256; i++) exp_mem[i] = '0;

        // reset values
        #12;
        chk("rst_init_done", DW'(init_done), DW'(0));
        chk("rst_readys",    DW'({w0_ready, w1_ready, rd_ready}), DW'(0));
        chk("rst_rv",        DW'(rd_resp_valid), DW'(0));
        chk("rst_wen",       DW'(sram_w_en), DW'(0));
        chk("rst_waddr",     DW'(sram_w_addr), DW'(0));
        chk("rst_wdata",     sram_w_data, '0);
        chk("rst_raddr",     DW'(sram_r_addr), DW'(0));

        init_sweep("init");

        // single write then read-back
        @(posedge clock); #1;
        w0_valid = 1'b1; w0_addr = 8'h10; w0_data = d0; w0_mask = 8'hFF;
        @(negedge clock);
        chk("w0_ready", DW'(w0_ready), DW'(1));
        @(posedge clock); #1;
        w0_valid = 1'b0;
        @(negedge clock);
        chk("wr_en",   DW'(sram_w_en),   DW'(1));
        chk("wr_addr", DW'(sram_w_addr), DW'(8'h10));
        chk("wr_data", sram_w_data, d0);
        chk("wr_mask", DW'(sram_w_mask), DW'(8'hFF));
        exp_mem[8'h10] = d0;
        @(posedge clock); #1;
        rd_valid = 1'b1; rd_addr = 8'h10;
        @(negedge clock);
        chk("rd_ready", DW'(rd_ready),    DW'(1));
        chk("rd_raddr", DW'(sram_r_addr), DW'(8'h10));
        chk("wr_idle",  DW'(sram_w_en),   DW'(0));
        @(posedge clock); #1;
        rd_valid = 1'b0;
        @(negedge clock);
        chk("rd_rv",   DW'(rd_resp_valid), DW'(1));
        chk("rd_data", rd_resp_data, d0);

        // round-robin arbitration
        a0 = '0; a1 = '0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
            w0_valid = ARB_V[i][0]; w1_valid = ARB_V[i][1];
            w0_addr = 8'h30 + a0; w0_data = {20{w0_addr}}; w0_mask = 8'hFF;
            w1_addr = 8'h40 + a1; w1_data = {20{w1_addr}}; w1_mask = 8'hFF;
            @(negedge clock);
            chk($sformatf("arb_g%0d", i), DW'({w1_ready, w0_ready}), DW'(ARB_G[i]));
            if (ARB_G[i][0]) begin exp_mem[w0_addr] = w0_data; a0++; end
            if (ARB_G[i][1]) begin exp_mem[w1_addr] = w1_data; a1++; end
        end
        @(posedge clock); #1;
        w0_valid = 1'b0; w1_valid = 1'b0;

        // same-cycle read/write collision on a zeroed entry
        @(posedge clock); #1;
        w0_valid = 1'b1; w0_addr = 8'h20; w0_data = '1; w0_mask = 8'h0F;
        @(negedge clock);
        chk("col_w0_ready", DW'(w0_ready), DW'(1));
        @(posedge clock); #1;
        w0_valid = 1'b0; rd_valid = 1'b1; rd_addr = 8'h20;
        @(negedge clock);
        chk("col_wen", DW'(sram_w_en), DW'(1));
        @(posedge clock); #1;
        rd_valid = 1'b0;
        @(negedge clock);
        chk("col_rv", DW'(rd_resp_valid), DW'(1));
`ifdef SRAM_PORT_CTRL_BYPASS_EN
        chk("col_data", rd_resp_data, lo_ones);
`else
        chk("col_data", rd_resp_data, '0);
`endif
        exp_mem[8'h20] = lo_ones;
        @(posedge clock); #1;
        rd_valid = 1'b1; rd_addr = 8'h20;
        @(posedge clock); #1;
        rd_valid = 1'b0;
        @(negedge clock);
        chk("col_follow", rd_resp_data, lo_ones);

        // back-to-back reads over the whole array
        for (int r = 0; r <= 256; r++) begin
            @(posedge clock); #1;
            rd_valid = (r < 256); rd_addr = AW'(r);
            @(negedge clock);
            if (r > 0) begin
                chk($sformatf("crd_v%0d", r - 1), DW'(rd_resp_valid), DW'(1));
                chk($sformatf("crd_d%0d", r - 1), rd_resp_data, exp_mem[r - 1]);
            end
        end
        @(posedge clock); #1;
        @(negedge clock);
        chk("crd_tail", DW'(rd_resp_valid), DW'(0));

        // reset with a write pending and a read in flight
        @(posedge clock); #1;
        w0_valid = 1'b1; w0_addr = 8'h77; w0_data = '1; w0_mask = 8'hFF;
        w1_valid = 1'b1; w1_addr = 8'h78; w1_data = '1; w1_mask = 8'hFF;
        rd_valid = 1'b1; rd_addr = 8'h10;
        @(negedge clock);
        chk("mid_rd_acc", DW'(rd_ready), DW'(1));
        @(posedge clock); #1;
        chk("mid_pre_wen", DW'(sram_w_en),     DW'(1));
        chk("mid_pre_rv",  DW'(rd_resp_valid), DW'(1));
        #1 reset = 1'b1;
        #1;
        chk("mid_readys", DW'({w0_ready, w1_ready, rd_ready}), DW'(0));
        chk("mid_rv",     DW'(rd_resp_valid), DW'(0));
        chk("mid_wen",    DW'(sram_w_en),     DW'(0));
        chk("mid_done",   DW'(init_done),     DW'(0));
        chk("mid_waddr",  DW'(sram_w_addr),   DW'(0));
        init_sweep("reinit");

        // the previously written entry must be zero again
        @(posedge clock); #1;
        rd_valid = 1'b1; rd_addr = 8'h10;
        @(posedge clock); #1;
        rd_valid = 1'b0;
        @(negedge clock);
        chk("reinit_rv",   DW'(rd_resp_valid), DW'(1));
        chk("reinit_data", rd_resp_data, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Controller sitting in front of one 256-entry x 160-bit two-port SRAM template (1 read port, 1 masked write port, 8 mask lanes of 20 bits).
- After reset it zero-initialises the whole array.
- It then arbitrates two write requesters (refill, update) round-robin and serves one read requester with fixed 1-cycle latency.
- Optional read-during-write bypass.

Parameters:
- ADDR_W, 8, SRAM address width (depth = 2**ADDR_W)
- DATA_W, 160, SRAM data width
- MASK_W, 8, write-mask lanes; lane width = DATA_W/MASK_W (20)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- init_done  out  1  high once init sweep finished
- w0_valid  in  1  refill write request
- w0_ready  out  1  refill write accepted this cycle
- w0_addr  in  ADDR_W  refill address
- w0_data  in  DATA_W  refill data
- w0_mask  in  MASK_W  refill lane mask
- w1_valid / w1_ready / w1_addr / w1_data / w1_mask  as w0, for the update requester
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted (= init_done)
- rd_addr  in  ADDR_W  read address
- rd_resp_valid  out  1  read data valid
- rd_resp_data  out  DATA_W  read data
- sram_r_addr  out  ADDR_W  to SRAM read address
- sram_r_data  in  DATA_W  from SRAM, valid the cycle after sram_r_addr
- sram_w_en  out  1  to SRAM write enable
- sram_w_addr  out  ADDR_W  to SRAM write address
- sram_w_data  out  DATA_W  to SRAM write data
- sram_w_mask  out  MASK_W  to SRAM write mask

Behaviour:
- Reset (async assert, deassert sampled on clock):
  - state=INIT, init counter=0, rr pointer=0 (w0 preferred).
  - Outputs: init_done, w0_ready, w1_ready, rd_ready, rd_resp_valid, sram_w_en = 0; all address/data/mask outputs = 0.
- INIT state:
  - Each cycle drives sram_w_en=1, sram_w_addr=counter, sram_w_data=0, sram_w_mask=all ones; counter increments.
  - After writing address 2**ADDR_W-1 (256 cycles) -> READY; init_done=1 from the next cycle.
  - All ready outputs are 0 during INIT.
- READY state:
  - Write arbitration is combinational from valids and the rr pointer.
    - Only one valid: that requester is granted.
    - Both valid: the requester pointed to by rr is granted; rr then points to the other.
    - A grant with only one requester valid leaves rr unchanged.
  - Ready asserts only for the granted requester; the handshake is valid&ready. Requesters must hold valid/addr/data/mask until ready.
  - Granted write is registered: sram_w_en/addr/data/mask drive the SRAM in the cycle after the handshake. Write latency is 1 cycle, throughput 1 write per cycle.
  - With no grant, sram_w_en=0 and the other write outputs hold their last value.
  - Read: rd_ready=init_done. sram_r_addr=rd_addr combinationally when rd_valid&rd_ready, otherwise holds its previous value.
  - rd_resp_valid is asserted exactly 1 cycle after each accepted read, with rd_resp_data=sram_r_data (or the bypassed value). Back-to-back reads are allowed every cycle.
- Ordering: a read accepted in cycle t observes every write whose sram_w_en was high before cycle t.
- Simultaneous read and write to the same address in one cycle: no stall; the result is governed by the optional feature.
- Reset mid-operation (any state): returns to INIT and redoes the full sweep. Accepted-but-unissued writes and in-flight read responses are dropped (rd_resp_valid=0).

Optional Feature:
- Macro SRAM_PORT_CTRL_BYPASS_EN.
- Defined: if a read is accepted in cycle t and sram_w_en=1 in cycle t with sram_w_addr equal to the read address:
  - the write's addr/data/mask are captured;
  - at t+1, rd_resp_data takes the written data in each lane whose mask bit is 1 and sram_r_data in the other lanes.
- Not defined: rd_resp_data=sram_r_data unconditionally, i.e. the pre-write contents on a same-cycle collision; no bypass registers are built.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - ADDR_W/DATA_W/MASK_W defaults and LANE_W=DATA_W/MASK_W;
  - state enum {INIT, READY};
  - a write-command struct {addr, data, mask}.
- One sub-module, rr_arb2: 2-way round-robin arbiter (valids, rr pointer update, one-hot grant).
- Init FSM, write register, read path and bypass merge stay in the top.

Test Plan:
- Reset, then idle 260 cycles -> sram_w_en high for exactly 256 cycles, addresses 0..255, data 0, mask 0xFF; init_done rises at cycle 257; no readys before.
- After init, w0 writes addr 0x10 data D0 mask 0xFF; read 0x10 two cycles later -> rd_resp_valid 1 cycle after accept, data=D0.
- w0 and w1 both valid for 4 cycles (distinct addresses) -> grants alternate w0,w1,w0,w1; with w1 alone valid, w1 granted every cycle and rr unchanged.
- Write addr 0x20 data all ones, mask 0x0F, over a zeroed entry, with the read of 0x20 in the same cycle sram_w_en is high:
  - BYPASS_EN defined: response low 80 bits ones, upper 80 zero;
  - BYPASS_EN undefined: all zeros.
  - A follow-up read returns low 80 bits ones in both builds.
- Reset asserted mid-READY while writes pending and a read in flight -> all readys, rd_resp_valid, sram_w_en low immediately; full 256-cycle sweep restarts from address 0.
- Continuous reads every cycle over 0..255 after init -> 256 consecutive rd_resp_valid cycles, each data matching the model, with no gaps.
